// File: rtl/scan_chain_pkg.sv
// Shared types for the scan chain driver: sequencer states and the sequence-length helper.
package scan_chain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    FIN
  } state_t;

  // Cycles from START acceptance to DONE inclusive; also the number of BUSY cycles.
  function automatic int seq_len(input int chain_len);
    return 2 * chain_len + 2;
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load, left-shifting register: MSB leaves first, new bits enter at the LSB.
module scan_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             shift_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], shift_in};
    end
  end

endmodule

// File: rtl/scan_chain_driver.sv
// Scan initiator: loads PAT into the chain, pulses one capture, unloads into CAPT.
// Optional compare-against-expected logic is built when SCAN_CMP_EN is defined.
module scan_chain_driver
  import scan_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 CLK,
  input  logic                 R,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
`ifdef SCAN_CMP_EN
  input  logic [CHAIN_LEN-1:0] EXP,
  input  logic [CHAIN_LEN-1:0] MASK,
  output logic                 MISMATCH,
  output logic                 ERR_STICKY,
`endif
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 CHAIN_EN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] CAPT
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             accept;
  logic             fin_entry;
  logic [CHAIN_LEN-1:0] load_q;
  logic [CHAIN_LEN-1:0] unload_q;
  logic [CHAIN_LEN-1:0] unload_next;
  logic             unused_bits;

  assign last        = (cnt == LAST);
  assign accept      = (state == IDLE) && START;
  assign fin_entry   = (state == SHIFT_OUT) && last;
  assign unload_next = {unload_q[CHAIN_LEN-2:0], SO};
  assign unused_bits = ^{load_q[CHAIN_LEN-2:0], unload_q[CHAIN_LEN-1]};

  always_ff @(posedge CLK) begin
    if (R) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (START) state_next = SHIFT_IN;
      SHIFT_IN:  if (last)  state_next = CAPTURE;
      CAPTURE:              state_next = SHIFT_OUT;
      SHIFT_OUT: if (last)  state_next = FIN;
      FIN:                  state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  always_comb begin
    SE       = 1'b0;
    SI       = 1'b0;
    CHAIN_EN = 1'b0;
    BUSY     = (state != IDLE);
    DONE     = 1'b0;
    case (state)
      SHIFT_IN: begin
        SE       = 1'b1;
        SI       = load_q[CHAIN_LEN-1];
        CHAIN_EN = 1'b1;
      end
      CAPTURE: begin
        CHAIN_EN = 1'b1;
      end
      SHIFT_OUT: begin
        SE       = 1'b1;
        CHAIN_EN = 1'b1;
      end
      FIN: begin
        DONE = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter restarts on every state change and saturates, so it never wraps inside a state.
  always_ff @(posedge CLK) begin
    if (R) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if ((state == SHIFT_IN || state == SHIFT_OUT) && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_load (
    .clk      (CLK),
    .rst      (R),
    .load     (accept),
    .load_val (PAT),
    .shift    (state == SHIFT_IN),
    .shift_in (1'b0),
    .q        (load_q)
  );

  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_unload (
    .clk      (CLK),
    .rst      (R),
    .load     (accept),
    .load_val ({CHAIN_LEN{1'b0}}),
    .shift    (state == SHIFT_OUT),
    .shift_in (SO),
    .q        (unload_q)
  );

  // The final SO sample lands in the same edge that enters FIN, so CAPT takes the shifted value.
  always_ff @(posedge CLK) begin
    if (R) begin
      CAPT <= '0;
    end else if (fin_entry) begin
      CAPT <= unload_next;
    end
  end

`ifdef SCAN_CMP_EN
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;
  logic                 mis_next;

  assign mis_next = |((unload_next ^ exp_q) & ~mask_q);

  always_ff @(posedge CLK) begin
    if (R) begin
      exp_q      <= '0;
      mask_q     <= '0;
      MISMATCH   <= 1'b0;
      ERR_STICKY <= 1'b0;
    end else begin
      if (accept) begin
        exp_q  <= EXP;
        mask_q <= MASK;
      end
      if (fin_entry) begin
        MISMATCH   <= mis_next;
        ERR_STICKY <= ERR_STICKY | mis_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver with a modelled 16-cell chain (inverting or identity capture).
// Compare checks are compiled in when SCAN_CMP_EN is defined.
module tb_scan_chain_driver;
  import scan_chain_pkg::*;

  localparam int N   = 16;
  localparam int SEQ = seq_len(N);

  logic         CLK;
  logic         R;
  logic         START;
  logic [N-1:0] PAT;
  logic         SO;
  logic         SE;
  logic         SI;
  logic         CHAIN_EN;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] CAPT;
`ifdef SCAN_CMP_EN
  logic [N-1:0] EXP;
  logic [N-1:0] MASK;
  logic         MISMATCH;
  logic         ERR_STICKY;
  logic         err_model;
`endif

  int compared   = 0;
  int mismatched = 0;

  scan_chain_driver #(.CHAIN_LEN(N)) dut (
    .CLK        (CLK),
    .R          (R),
    .START      (START),
    .PAT        (PAT),
`ifdef SCAN_CMP_EN
    .EXP        (EXP),
    .MASK       (MASK),
    .MISMATCH   (MISMATCH),
    .ERR_STICKY (ERR_STICKY),
`endif
    .SO         (SO),
    .SE         (SE),
    .SI         (SI),
    .CHAIN_EN   (CHAIN_EN),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .CAPT       (CAPT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External chain: shifts when SE, else captures D = ~Q (inverting) or D = Q (identity).
  logic [N-1:0] chain = '0;
  logic         chain_inv = 1'b1;
  always @(posedge CLK) begin
    if (CHAIN_EN === 1'b1) begin
      if (SE) chain <= {chain[N-2:0], SI};
      else    chain <= chain_inv ? ~chain : chain;
    end
  end
  assign SO = chain[N-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge in an idle cycle; START is raised here and accepted at the next edge.
  task automatic run_seq(input logic [N-1:0] pat, input logic inv, input logic poke, input string tag);
    int           done_cyc = 0;
    int           done_n   = 0;
    int           busy_n   = 0;
    int           en_n     = 0;
    logic [N-1:0] si_seen  = '0;
    logic [N-1:0] capt_at  = '0;
    logic [N-1:0] exp_capt;
`ifdef SCAN_CMP_EN
    logic [N-1:0] e_l = EXP;
    logic [N-1:0] m_l = MASK;
    logic         mis_at = 1'b0;
    logic         err_at = 1'b0;
    logic         mis_model;
`endif
    chain_inv = inv;
    exp_capt  = inv ? ~pat : pat;
    START = 1'b1;
    PAT   = pat;
    for (int c = 1; c <= SEQ + 1; c++) begin
      @(negedge CLK);
      if (BUSY)     busy_n++;
      if (CHAIN_EN) en_n++;
      if (c <= N) si_seen[N-c] = SI;
      if (DONE) begin
        done_n++;
        if (done_cyc == 0) begin
          done_cyc = c;
          capt_at  = CAPT;
`ifdef SCAN_CMP_EN
          mis_at = MISMATCH;
          err_at = ERR_STICKY;
`endif
        end
      end
      START = poke && (c == 5 || c == 20 || c == SEQ);
      if (c == 1) begin
        PAT = N'($urandom);
`ifdef SCAN_CMP_EN
        EXP  = N'($urandom);
        MASK = N'($urandom);
`endif
      end
    end
    START = 1'b0;
    check({tag, " done_cycle"}, done_cyc, SEQ);
    check({tag, " done_pulses"}, done_n, 1);
    check({tag, " busy_cycles"}, busy_n, SEQ);
    check({tag, " chain_en_cycles"}, en_n, 2 * N + 1);
    check({tag, " si_order"}, {16'h0, si_seen}, {16'h0, pat});
    check({tag, " capt"}, {16'h0, capt_at}, {16'h0, exp_capt});
    check({tag, " capt_held"}, {16'h0, CAPT}, {16'h0, exp_capt});
`ifdef SCAN_CMP_EN
    mis_model = |((exp_capt ^ e_l) & ~m_l);
    err_model = err_model | mis_model;
    check({tag, " mismatch"}, {31'h0, mis_at}, {31'h0, mis_model});
    check({tag, " err_sticky"}, {31'h0, err_at}, {31'h0, err_model});
    EXP  = e_l;
    MASK = m_l;
`endif
  endtask

  initial begin
    R     = 1'b1;
    START = 1'b0;
    PAT   = '0;
`ifdef SCAN_CMP_EN
    EXP       = '0;
    MASK      = '0;
    err_model = 1'b0;
`endif
    repeat (2) @(negedge CLK);
    check("rst busy", {31'h0, BUSY}, 0);
    check("rst se", {31'h0, SE}, 0);
    check("rst si", {31'h0, SI}, 0);
    check("rst chain_en", {31'h0, CHAIN_EN}, 0);
    check("rst done", {31'h0, DONE}, 0);
    check("rst capt", {16'h0, CAPT}, 0);
    R = 1'b0;
    @(negedge CLK);

`ifdef SCAN_CMP_EN
    EXP  = 16'h5A3C;
    MASK = '0;
`endif
    run_seq(16'hA5C3, 1'b1, 1'b0, "basic");
    run_seq(16'h8001, 1'b1, 1'b0, "si_order");
    run_seq(N'($urandom), 1'b1, 1'b1, "busy_ignore");
    run_seq(N'($urandom), 1'b1, 1'b0, "after_done");
    run_seq(16'hFFFF, 1'b0, 1'b0, "ident_ones");
    run_seq(16'h0000, 1'b0, 1'b0, "ident_zeros");
    for (int i = 0; i < 4; i++) begin
      run_seq(N'($urandom), 1'($urandom_range(0, 1)), 1'b0, "random");
    end

`ifdef SCAN_CMP_EN
    EXP  = 16'h5A3D;
    MASK = '0;
    run_seq(16'hA5C3, 1'b1, 1'b0, "cmp_fail");
    EXP  = 16'h5A3C;
    run_seq(16'hA5C3, 1'b1, 1'b0, "cmp_pass_sticky");
    EXP  = 16'h5A3D;
    MASK = 16'h0001;
    run_seq(16'hA5C3, 1'b1, 1'b0, "cmp_masked");
`endif

    // Abort in the middle of SHIFT_OUT with a two-cycle reset.
    chain_inv = 1'b1;
    START = 1'b1;
    PAT   = 16'h1234;
    @(negedge CLK);
    START = 1'b0;
    repeat (24) @(negedge CLK);
    check("abort busy_before", {31'h0, BUSY}, 1);
    R = 1'b1;
    repeat (2) @(negedge CLK);
    R = 1'b0;
    check("abort busy", {31'h0, BUSY}, 0);
    check("abort se", {31'h0, SE}, 0);
    check("abort chain_en", {31'h0, CHAIN_EN}, 0);
    check("abort done", {31'h0, DONE}, 0);
    check("abort capt", {16'h0, CAPT}, 0);
`ifdef SCAN_CMP_EN
    err_model = 1'b0;
    check("abort err_sticky", {31'h0, ERR_STICKY}, 0);
    EXP  = 16'h3DB9;
    MASK = '0;
`endif
    run_seq(16'hC246, 1'b1, 1'b0, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/scan_chain_driver.md
Name: scan_chain_driver

Overview:
Initiator side of the scan protocol used by the library's scan flip-flops (SE/SI/SO).
- Serially loads a parallel pattern into an external chain of CHAIN_LEN scan flops.
- Pulses one functional capture cycle.
- Shifts the captured state back out and presents it as a parallel word.
- Sits in the characterization/test harness between a pattern source and a cell-level scan chain.

Parameters:
CHAIN_LEN, 16, number of scan cells in the chain (>=2)
CNT_W, $clog2(CHAIN_LEN+1), localparam: width of shift counter (derived, not overridable)

Ports:
CLK  input  1  rising-edge clock for the driver and the chain (chain clock = CLK gated by CHAIN_EN)
R  input  1  reset, synchronous, active-high
START  input  1  request a load/capture/unload sequence; sampled only in IDLE
PAT  input  CHAIN_LEN  pattern to load; cell i receives PAT[i]
SO  input  1  scan out from chain cell CHAIN_LEN-1
SE  output  1  scan enable to chain
SI  output  1  scan data into chain cell 0
CHAIN_EN  output  1  chain clock enable (one chain edge per cycle when high)
BUSY  output  1  high whenever state != IDLE
DONE  output  1  one-cycle pulse: CAPT valid
CAPT  output  CHAIN_LEN  captured chain contents; CAPT[i] = cell i after capture

Behaviour:
- Clock and reset: one clock, CLK; reset R is synchronous and active-high.
- Reset (R high at a rising edge): state=IDLE, counter=0, shift regs=0.
  - Outputs after reset: SE=0, SI=0, CHAIN_EN=0, BUSY=0, DONE=0, CAPT=0.
  - Mid-sequence reset aborts immediately; chain contents are undefined and CAPT is cleared.
- States: IDLE -> SHIFT_IN -> CAPTURE -> SHIFT_OUT -> FIN -> IDLE.
- IDLE: SE=0, CHAIN_EN=0. START=1 latches PAT into the load register, clears the counter and moves to SHIFT_IN.
- SHIFT_IN, CHAIN_LEN cycles:
  - SE=1, CHAIN_EN=1.
  - SI = PAT[CHAIN_LEN-1-k] on shift k (MSB first), so after the last shift cell i holds PAT[i].
  - When the counter reaches CHAIN_LEN-1, go to CAPTURE.
- CAPTURE, 1 cycle: SE=0, CHAIN_EN=1 (functional D captured); then SHIFT_OUT.
- SHIFT_OUT, CHAIN_LEN cycles:
  - SE=1, CHAIN_EN=1, SI=0.
  - Each cycle, SO is sampled before the chain edge and shifted into the unload register LSB-side. First sample is cell CHAIN_LEN-1; after CHAIN_LEN samples, bit i = cell i.
- FIN, 1 cycle: SE=0, CHAIN_EN=0, DONE=1. CAPT is updated from the unload register at the FIN entry edge, held until the next FIN or reset. Next state IDLE.
- Latency: START accepted at edge t → DONE high in cycle t+2*CHAIN_LEN+2. BUSY is high for exactly 2*CHAIN_LEN+2 cycles.
- START while BUSY (including during FIN) is ignored, not queued.
- START in the cycle right after FIN is accepted normally; back-to-back sequences have one idle cycle minimum.
- PAT changes after acceptance have no effect on the running sequence.
- Counter saturates at CHAIN_LEN-1 and never wraps within a state; it is cleared on each state entry.

Optional Feature:
SCAN_CMP_EN
- Defined: adds input EXP[CHAIN_LEN] and input MASK[CHAIN_LEN] (both latched with PAT), plus outputs MISMATCH (1) and ERR_STICKY (1).
  - MISMATCH = |((CAPT ^ EXP_latched) & ~MASK_latched), valid with DONE and held with CAPT.
  - ERR_STICKY sets on any DONE with MISMATCH=1; cleared only by R.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package scan_chain_pkg: state enum (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FIN) and a function computing sequence length (2*CHAIN_LEN+2) for bench use.
- One sub-module is natural: scan_shift_reg, a parameterized load/shift register instantiated twice (load side MSB-out, unload side LSB-in).

Test Plan:
- Reset: R=1 for 2 cycles mid-SHIFT_OUT → next cycle BUSY=0, SE=0, CHAIN_EN=0, CAPT=0; a subsequent START runs a full sequence correctly.
- Basic: CHAIN_LEN=16, bench models the chain with D_func = ~Q. PAT=16'hA5C3 → DONE at START+34, CAPT=16'h5A3C.
- SI order: PAT=16'h8001 → SI=1 on shift 0 and shift 15, else 0; CHAIN_EN high 33 cycles total.
- Busy ignore: START pulsed at cycles 5, 20 and on the DONE cycle → exactly one DONE pulse. START one cycle after DONE → second DONE 34 cycles later.
- Identity chain (D_func = Q), PAT=16'hFFFF then 16'h0000 back-to-back → CAPT=16'hFFFF, then 16'h0000.
- SCAN_CMP_EN: EXP=16'h5A3C, MASK=0 with the inverting chain → MISMATCH=0. EXP=16'h5A3D → MISMATCH=1 and ERR_STICKY=1, still 1 after the next passing sequence until R.
